// File: rtl/display_spi_pkg.sv
// Shared constants and state encoding for the Nexys4Display SPI scheduler.
// A frame carries a command nibble, a digit select and a data byte.
package display_spi_pkg;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned CMD_MSB   = 15;
  localparam int unsigned CMD_LSB   = 12;
  localparam int unsigned DIGIT_MSB = 11;
  localparam int unsigned DIGIT_LSB = 8;
  localparam int unsigned DATA_MSB  = 7;
  localparam int unsigned DATA_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StTrail,
    StGap
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, and the pointer moves past
// the served requester on accept.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // Requester served last; reset value 1 makes req 0 win the first tie.
  logic last_q, last_d;

  always_comb begin
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_d = accept_i ? grant_o[1] : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/display_spi_scheduler.sv
// SPI master for the Nexys4Display slave with a two-requester round-robin front end.
// Frames go out MSB first; MISO is captured on each SCLK rising edge.
module display_spi_scheduler
  import display_spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned SS_LEAD   = 1,
  parameter int unsigned SS_TRAIL  = 1,
  parameter int unsigned GAP       = 2
) (
  input  logic                 clk_5m_i,
  input  logic                 rst_low_i,
  input  logic [1:0]           req_valid_i,
  input  logic [2*FRAME_W-1:0] req_frame_i,
  output logic [1:0]           req_ready_o,
  output logic                 busy_o,
  output logic [FRAME_W-1:0]   rx_frame_o,
  output logic                 rx_valid_o,
  output logic                 spi_sclk_o,
  output logic                 spi_ss_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i
);

  localparam int unsigned HalfW = $clog2(SCLK_HALF);
  localparam int unsigned BitW  = $clog2(FRAME_W);
  localparam int unsigned SegW  = 8;

  state_e               state_q, state_d;
  logic [HalfW-1:0]     half_q, half_d, half_nxt;
  logic [SegW-1:0]      seg_q, seg_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d, rx_sh_q, rx_sh_d, rx_frame_q, rx_frame_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic [1:0]           grant;
  logic                 accept, half_last;

  rr_arbiter2 u_arb (
    .clk_i    (clk_5m_i),
    .rst_ni   (rst_low_i),
    .valid_i  (req_valid_i),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // Ready is held low while reset is asserted even though the state already reads idle.
  assign req_ready_o = (state_q == StIdle && rst_low_i) ? grant : 2'b00;
  assign accept      = |(req_valid_i & req_ready_o);
  assign busy_o      = (state_q != StIdle) | accept;
  assign half_last   = (half_q == HalfW'(SCLK_HALF - 1));
  assign half_nxt    = half_last ? '0 : half_q + HalfW'(1);

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    seg_d      = seg_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_frame_d = rx_frame_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_d    = grant[1] ? req_frame_i[2*FRAME_W-1:FRAME_W] : req_frame_i[FRAME_W-1:0];
          ss_d    = 1'b0;
          half_d  = '0;
          seg_d   = '0;
          state_d = StLead;
        end
      end
      StLead: begin
        half_d = half_nxt;
        if (half_last) begin
          if (seg_q == SegW'(SS_LEAD - 1)) begin
            seg_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            mosi_d  = tx_q[FRAME_W-1];
            tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
            state_d = StShift;
          end else begin
            seg_d = seg_q + SegW'(1);
          end
        end
      end
      StShift: begin
        half_d = half_nxt;
        if (half_last) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[FRAME_W-2:0], spi_miso_i};
          end else if (bit_q == BitW'(FRAME_W - 1)) begin
            state_d = StTrail;
          end else begin
            bit_d  = bit_q + BitW'(1);
            sclk_d = 1'b0;
            mosi_d = tx_q[FRAME_W-1];
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      StTrail: begin
        half_d = half_nxt;
        if (half_last) begin
          if (seg_q == SegW'(SS_TRAIL - 1)) begin
            seg_d      = '0;
            ss_d       = 1'b1;
            mosi_d     = 1'b1;
            rx_frame_d = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = StGap;
          end else begin
            seg_d = seg_q + SegW'(1);
          end
        end
      end
      StGap: begin
        if (seg_q == SegW'(GAP - 1)) begin
          seg_d   = '0;
          state_d = StIdle;
        end else begin
          seg_d = seg_q + SegW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_5m_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      state_q    <= StIdle;
      half_q     <= '0;
      seg_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_frame_q <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b1;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      seg_q      <= seg_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_frame_q <= rx_frame_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
    end
  end

  assign rx_frame_o = rx_frame_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_sclk_o = sclk_q;
  assign spi_ss_o   = ss_q;
  assign spi_mosi_o = mosi_q;

endmodule
